// File: rtl/id_regfile_pipe.sv
// id_regfile_pipe: MIPS decode stage with register file and a one-entry ID/EX output register; ID_BYPASS_EN adds write-back bypass.
// Latency: an accepted Ins appears on the ID/EX outputs 1 cycle later.
// Backpressure: in_ready drops while ID/EX is full and not drained, during a load-use hazard, and during flush.
module id_regfile_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Ins,
    input  logic [DATA_W-1:0] Pc4,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] Wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    output logic [DATA_W-1:0] Ed32,
    output logic [ADDR_W-1:0] Wadr,
    output logic              Wflg,
    output logic              out_is_load
);
    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [ADDR_W:0] REG_LIM = (ADDR_W + 1)'(REG_NUM);

    logic [DATA_W-1:0] regs [REG_NUM];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;

    assign op    = Ins[31:26];
    assign rs    = ADDR_W'(Ins[25:21]);
    assign rt    = ADDR_W'(Ins[20:16]);
    assign rd    = ADDR_W'(Ins[15:11]);
    assign shamt = Ins[10:6];
    assign funct = Ins[5:0];
    assign imm   = Ins[15:0];
    assign sext  = {{(DATA_W-16){imm[15]}}, imm};
    assign zext  = {{(DATA_W-16){1'b0}}, imm};

    logic wb_ok;
    assign wb_ok = wb_en && (wb_adr != '0) && ({1'b0, wb_adr} < REG_LIM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[wb_adr] <= Wdata;
        end
    end

    logic [DATA_W-1:0] rf_rs;
    logic [DATA_W-1:0] rf_rt;

    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (rs != '0 && {1'b0, rs} < REG_LIM) rf_rs = regs[rs];
        if (rt != '0 && {1'b0, rt} < REG_LIM) rf_rt = regs[rt];
`ifdef ID_BYPASS_EN
        // write-first: wb_ok already excludes register 0
        if (wb_ok && wb_adr == rs) rf_rs = Wdata;
        if (wb_ok && wb_adr == rt) rf_rt = Wdata;
`endif
    end

    logic [DATA_W-1:0] d_rd1;
    logic [DATA_W-1:0] d_rd2;
    logic [DATA_W-1:0] d_ed;
    logic [ADDR_W-1:0] d_wadr;
    logic              d_wflg;
    logic              d_load;
    logic              d_uses_rt;

    always_comb begin
        d_rd1     = '0;
        d_rd2     = '0;
        d_ed      = '0;
        d_wadr    = '0;
        d_wflg    = 1'b0;
        d_load    = 1'b0;
        d_uses_rt = 1'b0;
        case (op)
            OP_R: begin
                d_rd1     = rf_rs;
                d_rd2     = rf_rt;
                d_ed      = DATA_W'(shamt);
                d_wadr    = rd;
                d_uses_rt = 1'b1;
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: d_wflg = 1'b1;
                    default:      d_wflg = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                d_rd1  = rf_rs;
                d_rd2  = rf_rt;
                d_ed   = sext;
                d_wadr = rt;
                d_wflg = 1'b1;
                d_load = (op == OP_LW);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                d_rd1  = rf_rs;
                d_rd2  = rf_rt;
                d_ed   = zext;
                d_wadr = rt;
                d_wflg = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                d_rd1     = rf_rs;
                d_rd2     = rf_rt;
                d_ed      = sext;
                d_wadr    = rt;
                d_uses_rt = (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
            end
            OP_JAL: begin
                d_ed   = Pc4 + DATA_W'(4);
                d_wadr = ADDR_W'(LINK_REG);
                d_wflg = 1'b1;
            end
            default: ;
        endcase
    end

    // A held LW cannot deliver its data in time for a dependent instruction.
    logic hazard;
    logic accept;

    assign hazard   = out_valid && out_is_load && (Wadr != '0) &&
                      ((Wadr == rs) || ((Wadr == rt) && d_uses_rt));
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

`ifdef ID_BYPASS_EN
    logic              d_byp;
    logic [ADDR_W-1:0] h_rs;
    logic [ADDR_W-1:0] h_rt;
    logic              h_byp;

    // J, JAL and unknown opcodes carry no register operands
    assign d_byp = op inside {OP_R, OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI,
                              OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
                              OP_LW, OP_SW};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_rs  <= '0;
            h_rt  <= '0;
            h_byp <= 1'b0;
        end else if (accept) begin
            h_rs  <= rs;
            h_rt  <= rt;
            h_byp <= d_byp;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid   <= 1'b0;
            Rdata1      <= '0;
            Rdata2      <= '0;
            Ed32        <= '0;
            Wadr        <= '0;
            Wflg        <= 1'b0;
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            Rdata1      <= d_rd1;
            Rdata2      <= d_rd2;
            Ed32        <= d_ed;
            Wadr        <= d_wadr;
            Wflg        <= d_wflg;
            out_is_load <= d_load;
        end else if (out_ready) begin
            out_valid <= 1'b0;
`ifdef ID_BYPASS_EN
        end else if (out_valid && h_byp && wb_ok) begin
            // stalled: keep held operands current so EX never sees stale data
            if (wb_adr == h_rs) Rdata1 <= Wdata;
            if (wb_adr == h_rt) Rdata2 <= Wdata;
`endif
        end
    end

endmodule

// File: tb/tb_id_regfile_pipe.sv
// Bench for id_regfile_pipe: random and directed stimulus, expected decodes queued at accept and compared by a monitor.
module tb_id_regfile_pipe;
    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Ins;
    logic [31:0] Pc4;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_adr;
    logic [31:0] Wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;
    logic [4:0]  Wadr;
    logic        Wflg;
    logic        out_is_load;

    always #5 CLK = ~CLK;

    id_regfile_pipe dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins), .Pc4(Pc4),
        .flush(flush), .wb_en(wb_en), .wb_adr(wb_adr), .Wdata(Wdata), .out_valid(out_valid),
        .out_ready(out_ready), .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32), .Wadr(Wadr),
        .Wflg(Wflg), .out_is_load(out_is_load)
    );

    typedef struct {
        logic [31:0] rd1, rd2, ed;
        logic [4:0]  wadr, rs, rt;
        logic        wflg, ld, chk_rd2, chk_wadr, reads;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic        mvalid;
    logic        mld;
    logic [4:0]  mdst;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc4);
        exp_t e;
        logic [5:0]  op;
        logic [31:0] r_s, r_t, sx, zx;
        op = ins[31:26];
        e = '{default: 0};
        e.chk_rd2 = 1'b1;
        e.chk_wadr = 1'b1;
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        r_s = mregs[e.rs];
        r_t = mregs[e.rt];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        case (op)
            6'h00: begin
                e.reads = 1'b1; e.rd1 = r_s; e.rd2 = r_t; e.ed = {27'h0, ins[10:6]};
                e.wadr = ins[15:11];
                e.wflg = ins[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                          6'h09, 6'h10, 6'h12};
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin
                e.reads = 1'b1; e.rd1 = r_s; e.chk_rd2 = 1'b0; e.ed = sx; e.wadr = e.rt;
                e.wflg = 1'b1; e.ld = (op == 6'h23);
            end
            6'h0C, 6'h0D, 6'h0E: begin
                e.reads = 1'b1; e.rd1 = r_s; e.chk_rd2 = 1'b0; e.ed = zx; e.wadr = e.rt;
                e.wflg = 1'b1;
            end
            6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01: begin
                e.reads = 1'b1; e.rd1 = r_s; e.rd2 = r_t; e.ed = sx; e.chk_wadr = 1'b0;
            end
            6'h03: begin
                e.ed = pc4 + 32'd4; e.wadr = 5'd31; e.wflg = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic uses_rt(input logic [31:0] ins);
        return ins[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05};
    endfunction

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0]  ops [18] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                  6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h23, 6'h2B, 6'h3F};
        logic [5:0]  fns [12] = '{6'h00, 6'h02, 6'h08, 6'h09, 6'h10, 6'h11, 6'h18, 6'h20,
                                  6'h22, 6'h25, 6'h2A, 6'h3F};
        logic [31:0] r;
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 17)];
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        if (r[31:26] == 6'h00) begin
            r[15:11] = 5'($urandom_range(0, 7));
            r[5:0] = fns[$urandom_range(0, 11)];
        end
        return r;
    endfunction

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Rdata1", Rdata1, 32'd0);
        check("rst_Rdata2", Rdata2, 32'd0);
        check("rst_Ed32", Ed32, 32'd0);
        check("rst_Wadr", 32'(Wadr), 32'd0);
        check("rst_Wflg", 32'(Wflg), 32'd0);
        check("rst_out_is_load", 32'(out_is_load), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        wb_en = 1'b0;
        flush = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        mvalid = 1'b0;
        mld = 1'b0;
        mdst = 5'd0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // One clock of stimulus; called just after a rising edge, returns just after the next one.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc4,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ordy);
        logic hz, exp_rdy, acc;
        in_valid = iv; Ins = ins; Pc4 = pc4; flush = fl;
        wb_en = we; wb_adr = wa; Wdata = wd; out_ready = ordy;
        #1;
        hz = mvalid && mld && (mdst != 5'd0) &&
             ((mdst == ins[25:21]) || ((mdst == ins[20:16]) && uses_rt(ins)));
        exp_rdy = (!mvalid || ordy) && !hz && !fl;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(mvalid));
        acc = iv && exp_rdy;
        if (acc) sb.push_back(decode(ins, pc4));
        if (fl && mvalid && sb.size() > 0) sb.delete(sb.size() - 1);
        @(posedge CLK);
        if (we && wa != 5'd0) mregs[wa] = wd;
        if (fl) mvalid = 1'b0;
        else if (acc) begin
            mvalid = 1'b1;
            mld = (ins[31:26] == 6'h23);
            mdst = ins[20:16];
        end else if (ordy) mvalid = 1'b0;
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, ordy);
    endtask

    // Monitor: every completed ID/EX transfer is matched against the oldest queued expectation.
    initial begin
        exp_t        e;
        logic [31:0] x1, x2;
        forever begin
            @(negedge CLK);
            if (!RST && out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: out_valid=1 with no queued decode at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    x1 = e.rd1;
                    x2 = e.rd2;
`ifdef ID_BYPASS_EN
                    // bypass keeps operands current until the transfer edge
                    if (e.reads) begin
                        x1 = mregs[e.rs];
                        x2 = mregs[e.rt];
                    end
`endif
                    check("Rdata1", Rdata1, x1);
                    if (e.chk_rd2) check("Rdata2", Rdata2, x2);
                    check("Ed32", Ed32, e.ed);
                    if (e.chk_wadr) check("Wadr", 32'(Wadr), 32'(e.wadr));
                    check("Wflg", 32'(Wflg), 32'(e.wflg));
                    check("out_is_load", 32'(out_is_load), 32'(e.ld));
                end
            end
        end
    end

    initial begin
        RST = 1'b0;
        in_valid = 1'b0; Ins = 32'h0; Pc4 = 32'h0; flush = 1'b0;
        wb_en = 1'b0; wb_adr = 5'd0; Wdata = 32'h0; out_ready = 1'b0;
        #2;
        do_reset();

        cycle(1'b1, i_ins(8, 0, 8, 16'hFFFF), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b1, i_ins(13, 0, 9, 16'hFFFF), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b1);
        cycle(1'b1, r_ins(0, 0, 1, 32), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1111, 1'b1);
        cycle(1'b1, r_ins(5, 5, 2, 32), 32'h0, 1'b0, 1'b1, 5'd5, 32'hA5A5, 1'b1);
        cycle(1'b1, i_ins(35, 1, 4, 0), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        repeat (2) cycle(1'b1, r_ins(4, 0, 6, 32), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b1, {6'h03, 26'h0}, 32'h00400004, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b1, {6'h02, 26'h123}, 32'h00400008, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle(1'b1, r_ins(1, 2, 3, 32), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        repeat (3) idle(1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        idle(1'b1);
        cycle(1'b1, i_ins(8, 5, 7, 16'h0042), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        idle(1'b0);
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 9) < 8, rand_ins(), $urandom, $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 7);
        end

        repeat (3) idle(1'b1);
        check("drain_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
